// File: rtl/otter_pkg.sv
// Shared OTTER core definitions: RV32I opcodes, instruction layout and the
// trap sequencer state encoding.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    opcode_t    opcode;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } trap_state_t;

  localparam logic [31:0] MRET_INSTR = 32'h30200073;

  function automatic logic is_mret(input logic [31:0] ir);
    return ir == MRET_INSTR;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level input with a one-cycle
// pulse on each rising edge seen at the synchronizer output.
module sync_edge_det
  import otter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    last_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/otter_trap_ctrl.sv
// Interrupt/MRET sequencer for the 5-stage OTTER pipeline: takes a pending
// interrupt at a valid EX instruction, drains MEM/WB, then redirects to mtvec.
module otter_trap_ctrl
  import otter_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INTR,
  input  logic [31:0] mtvec,
  input  logic        csr_mie_we,
  input  logic        csr_mie_wdata,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_pc,
  input  logic        ex_mret,
  output logic        if_stall,
  output logic        flush_front,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mepc,
  output logic        mie,
  output logic        busy
);

  localparam int CNT_W = 3;

  trap_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [31:0]      mepc_q, mepc_d;
  logic             mie_q, mie_d;

  logic             intr_rise;
  logic             mret_now;
  logic             take;
  logic             if_stall_c, flush_c, redirect_c;
  logic [31:0]      redirect_pc_c;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK     (CLK),
    .RESET   (RESET),
    .async_in(INTR),
    .rise    (intr_rise)
  );

  assign mret_now = ex_valid && ex_mret;
  assign take     = pending_q && mie_q && ex_valid && !ex_mret;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q | intr_rise;
    mepc_d        = mepc_q;
    mie_d         = mie_q;
    if_stall_c    = 1'b0;
    flush_c       = 1'b0;
    redirect_c    = 1'b0;
    redirect_pc_c = '0;
    case (state_q)
      IDLE: begin
        if (mret_now) begin
          redirect_c    = 1'b1;
          redirect_pc_c = mepc_q;
          flush_c       = 1'b1;
          mie_d         = 1'b1;
        end else begin
          if (csr_mie_we) mie_d = csr_mie_wdata;
          // The EX instruction retires normally; resume after it.
          if (take) begin
            mepc_d  = ex_branch_taken ? ex_branch_pc : ex_pc + 32'd4;
            flush_c = 1'b1;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if_stall_c = 1'b1;
        flush_c    = 1'b1;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = TRAP;
      end
      TRAP: begin
        redirect_c    = 1'b1;
        redirect_pc_c = mtvec;
        flush_c       = 1'b1;
        mie_d         = 1'b0;
        // An edge landing in this very cycle must not be lost.
        pending_d     = intr_rise;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      mepc_q    <= '0;
      mie_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      mepc_q    <= mepc_d;
      mie_q     <= mie_d;
    end
  end

  // Outputs read as zero while RESET is held, whatever the pipeline shows.
  assign if_stall       = !RESET && if_stall_c;
  assign flush_front    = !RESET && flush_c;
  assign redirect_valid = !RESET && redirect_c;
  assign redirect_pc    = RESET ? '0 : redirect_pc_c;
  assign mepc           = RESET ? '0 : mepc_q;
  assign mie            = !RESET && mie_q;
  assign busy           = !RESET && (state_q != IDLE);

endmodule

// File: doc/otter_trap_ctrl.md
Name: otter_trap_ctrl

Overview:
- Interrupt/trap sequencer for the 5-stage pipelined OTTER core.
- Synchronizes and latches the external INTR line, waits for a valid instruction in EX, then flushes the front end and drains MEM/WB.
- Redirects fetch to mtvec and maintains MEPC and the machine interrupt-enable bit (MIE).
- Also sequences MRET: redirects fetch to MEPC and restores MIE.
- Sits beside the EX-stage branch logic; its redirect takes priority over the EX branch redirect in the PC mux.

Parameters:
- DRAIN_CYCLES, 2, cycles fetch is held after the take cycle so the MEM and WB instructions retire; legal 1..7.
- SYNC_STAGES, 2, flip-flop depth of the INTR synchronizer; legal 2..4.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- INTR  in  1  asynchronous external interrupt request, level; a rising edge requests an interrupt.
- mtvec  in  32  trap vector, from the CSR file.
- csr_mie_we  in  1  CSR instruction writing mstatus.MIE this cycle.
- csr_mie_wdata  in  1  new MIE value.
- ex_valid  in  1  EX holds a real instruction, not a bubble.
- ex_pc  in  32  PC of the EX instruction.
- ex_branch_taken  in  1  EX resolves a taken jump or branch.
- ex_branch_pc  in  32  target of that jump or branch.
- ex_mret  in  1  EX holds MRET; qualified by ex_valid.
- if_stall  out  1  hold the PC register and the IF/DE register.
- flush_front  out  1  load NOPs into IF/DE and DE/EX.
- redirect_valid  out  1  next_pc = redirect_pc this cycle.
- redirect_pc  out  32  redirect target.
- mepc  out  32  saved resume PC.
- mie  out  1  machine interrupt enable.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, pending=0, counter=0, synchronizer flops=0, mepc=0, mie=0. Reset in any state, including mid-DRAIN, aborts the sequence with no redirect.
- Synchronizer: INTR passes through SYNC_STAGES flops. A rising edge on the last flop, compared with a registered copy, sets pending.
- pending is sticky. It clears only in the TRAP cycle. A new edge in the TRAP cycle wins and pending stays 1.
- States: IDLE, DRAIN, TRAP.
- IDLE, priority order:
  1. ex_valid && ex_mret: redirect_valid=1, redirect_pc=mepc, flush_front=1, mie<=1 next edge. Stay in IDLE. An interrupt, even if pending, is not taken this cycle.
  2. take = pending && mie && ex_valid && !ex_mret:
     - mepc <= ex_branch_taken ? ex_branch_pc : ex_pc+4 (mod 2^32).
     - flush_front=1, counter <= DRAIN_CYCLES, go to DRAIN.
     - The EX instruction completes normally; no redirect this cycle.
  3. Otherwise all outputs are 0 (mepc and mie hold). Bubbles in EX (ex_valid=0) never take an interrupt.
- csr_mie_we updates mie in IDLE when no MRET is present. MRET wins over a simultaneous CSR write. In DRAIN and TRAP, csr_mie_we is ignored.
- DRAIN:
  - if_stall=1, flush_front=1, busy=1; counter decrements each cycle.
  - When counter==1, go to TRAP.
  - Latency from the take cycle to the TRAP cycle = DRAIN_CYCLES+1.
  - ex_* inputs are ignored because EX holds bubbles.
- TRAP (exactly one cycle):
  - redirect_valid=1, redirect_pc=mtvec, flush_front=1, if_stall=0, busy=1.
  - mie<=0, pending<=0 (subject to the new-edge rule), go to IDLE.
- mtvec is sampled only in the TRAP cycle.
- An MRET can never be in EX during DRAIN or TRAP, because of the flushes.

Decomposition:
- Shared package otter_pkg holds:
  - the opcode enum and instr_t, already used by the core;
  - typedef enum trap_state_t {IDLE, DRAIN, TRAP};
  - MRET encoding constant 32'h30200073.
- One natural sub-module: sync_edge_det, parameterized by SYNC_STAGES, producing a one-cycle rise pulse.

Test Plan:
- Reset: drive RESET mid-DRAIN → next cycle busy=0, mie=0, mepc=0, no redirect_valid pulse ever follows.
- Basic interrupt:
  - Stimulus: mie=1, INTR rises, EX holds ex_pc=0x100 with no branch, mtvec=0x200.
  - Take cycle: flush_front=1 with redirect_valid=0. This is 3 cycles after the INTR edge with SYNC_STAGES=2.
  - DRAIN: 2 cycles with if_stall=1.
  - TRAP: redirect_valid=1, redirect_pc=0x200.
  - After TRAP: mepc=0x104, mie=0.
- Branch in EX: take while ex_branch_taken=1, ex_branch_pc=0x3C0 → mepc=0x3C0.
- Masking and bubbles:
  - Stimulus: mie=0 with INTR edge, then a bubble in EX, then a CSR write setting MIE=1, then ex_valid=1.
  - Required: the interrupt is taken only at the first valid EX cycle after mie=1.
- MRET priority:
  - Stimulus: mepc=0x104, pending=1, ex_mret=1 in EX.
  - That cycle: redirect_pc=0x104, redirect_valid=1.
  - Next cycle: mie=1; the interrupt is taken at the next valid EX instruction.
- Edge during TRAP: a second INTR edge arriving at the TRAP cycle leaves pending=1. No take occurs until mie=1.
